// File: rtl/cursor_ctrl_if.sv
// Joystick-in / cursor-out bundle between the SPI reader, cursor_ctrl and the sprite renderer.
interface cursor_ctrl_if #(
    parameter int unsigned JW = 10,
    parameter int unsigned PW = 10
);
    logic          tick;
    logic          recenter;
    logic          enable;
    logic [JW-1:0] joy_x;
    logic [JW-1:0] joy_y;
    logic [PW-1:0] dot_x;
    logic [PW-1:0] dot_y;
    logic [3:0]    at_edge;
    logic          moving;

    modport master (
        output tick, recenter, enable, joy_x, joy_y,
        input  dot_x, dot_y, at_edge, moving
    );

    modport slave (
        input  tick, recenter, enable, joy_x, joy_y,
        output dot_x, dot_y, at_edge, moving
    );
endinterface

// File: rtl/cursor_ctrl.sv
// Joystick-to-cursor controller: zone decode, per-axis hold acceleration, clamped position update per tick edge.
module cursor_ctrl #(
    parameter int unsigned JW          = 10,
    parameter int unsigned PW          = 10,
    parameter int unsigned X_MIN       = 574,
    parameter int unsigned X_MAX       = 734,
    parameter int unsigned Y_MIN       = 71,
    parameter int unsigned Y_MAX       = 471,
    parameter int unsigned X_INIT      = 724,
    parameter int unsigned Y_INIT      = 171,
    parameter int unsigned TH_FAR_LO   = 150,
    parameter int unsigned TH_NEAR_LO  = 400,
    parameter int unsigned TH_NEAR_HI  = 600,
    parameter int unsigned TH_FAR_HI   = 850,
    parameter int unsigned STEP_SLOW   = 10,
    parameter int unsigned STEP_FAST   = 20,
    parameter int unsigned ACCEL_TICKS = 8,
    parameter int unsigned STEP_MAX    = 40,
    parameter bit          X_INV       = 1'b1,
    parameter bit          Y_INV       = 1'b0
) (
    input logic          clk,
    input logic          clr_n,
    cursor_ctrl_if.slave bus
);
    localparam int unsigned SW       = PW + 1;
    localparam int unsigned HW       = $clog2(ACCEL_TICKS + 1);
    localparam int unsigned ACC_SLOW = (2 * STEP_SLOW > STEP_MAX) ? STEP_MAX : 2 * STEP_SLOW;
    localparam int unsigned ACC_FAST = (2 * STEP_FAST > STEP_MAX) ? STEP_MAX : 2 * STEP_FAST;

    if (!(X_MIN <= X_INIT && X_INIT <= X_MAX && Y_MIN <= Y_INIT && Y_INIT <= Y_MAX &&
          STEP_MAX >= STEP_FAST && STEP_FAST >= STEP_SLOW && STEP_SLOW > 0)) begin : g_param_err
        $error("cursor_ctrl: illegal bound/init or step parameter set");
    end

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_ACCEL = 2'd2} state_t;

    // axis index 0 = x, 1 = y
    state_t             r_state [2];
    state_t             w_state_nxt [2];
    logic [HW-1:0]      r_hold [2];
    logic [HW-1:0]      w_hold_nxt [2];
    logic signed [1:0]  r_dir [2];
    logic signed [1:0]  w_dir_nxt [2];
    logic [PW-1:0]      r_pos [2];
    logic [PW-1:0]      w_pos_nxt [2];
    logic               r_tick_d;
    logic               r_moving;
    logic               w_moving_nxt;
    logic               w_upd;
    logic [JW-1:0]      w_sample [2];
    logic [PW-1:0]      w_min [2];
    logic [PW-1:0]      w_max [2];
    logic [PW-1:0]      w_init [2];
    logic               w_inv [2];
    logic signed [1:0]  w_dir [2];
    logic               w_fast [2];
    logic [SW-1:0]      w_step [2];
    logic signed [SW-1:0] w_sum [2];

    assign w_sample[0] = bus.joy_x;
    assign w_sample[1] = bus.joy_y;
    assign w_min[0]    = PW'(X_MIN);
    assign w_min[1]    = PW'(Y_MIN);
    assign w_max[0]    = PW'(X_MAX);
    assign w_max[1]    = PW'(Y_MAX);
    assign w_init[0]   = PW'(X_INIT);
    assign w_init[1]   = PW'(Y_INIT);
    assign w_inv[0]    = X_INV;
    assign w_inv[1]    = Y_INV;

    assign w_upd = bus.tick & ~r_tick_d & bus.enable & ~bus.recenter;

    // Zone decode: direction (sign-flipped by INV) and fast/slow band per axis.
    always_comb begin
        for (int a = 0; a < 2; a++) begin
            w_dir[a]  = 2'sd0;
            w_fast[a] = 1'b0;
            if (w_sample[a] < JW'(TH_FAR_LO)) begin
                w_dir[a]  = -2'sd1;
                w_fast[a] = 1'b1;
            end else if (w_sample[a] < JW'(TH_NEAR_LO)) begin
                w_dir[a]  = -2'sd1;
            end else if (w_sample[a] > JW'(TH_FAR_HI)) begin
                w_dir[a]  = 2'sd1;
                w_fast[a] = 1'b1;
            end else if (w_sample[a] > JW'(TH_NEAR_HI)) begin
                w_dir[a]  = 2'sd1;
            end
            if (w_inv[a]) begin
                w_dir[a] = -w_dir[a];
            end
        end
    end

    // FSM state register: state, hold count and last direction per axis.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int a = 0; a < 2; a++) begin
                r_state[a] <= ST_IDLE;
                r_hold[a]  <= '0;
                r_dir[a]   <= 2'sd0;
            end
        end else begin
            for (int a = 0; a < 2; a++) begin
                r_state[a] <= w_state_nxt[a];
                r_hold[a]  <= w_hold_nxt[a];
                r_dir[a]   <= w_dir_nxt[a];
            end
        end
    end

    // FSM next state: a reversal restarts the hold count, same direction counts up to saturation.
    always_comb begin
        for (int a = 0; a < 2; a++) begin
            w_state_nxt[a] = r_state[a];
            w_hold_nxt[a]  = r_hold[a];
            w_dir_nxt[a]   = r_dir[a];
            if (!bus.enable || bus.recenter) begin
                w_state_nxt[a] = ST_IDLE;
                w_hold_nxt[a]  = '0;
                w_dir_nxt[a]   = 2'sd0;
            end else if (w_upd) begin
                if (w_dir[a] == 2'sd0) begin
                    w_state_nxt[a] = ST_IDLE;
                    w_hold_nxt[a]  = '0;
                    w_dir_nxt[a]   = 2'sd0;
                end else begin
                    if (r_state[a] == ST_IDLE || w_dir[a] != r_dir[a]) begin
                        w_hold_nxt[a] = HW'(1);
                    end else if (r_hold[a] < HW'(ACCEL_TICKS)) begin
                        w_hold_nxt[a] = r_hold[a] + HW'(1);
                    end
                    w_dir_nxt[a]   = w_dir[a];
                    w_state_nxt[a] = (w_hold_nxt[a] >= HW'(ACCEL_TICKS)) ? ST_ACCEL : ST_RUN;
                end
            end
        end
    end

    // FSM outputs: step size from band and current state, clamped next position and moving flag.
    always_comb begin
        w_moving_nxt = 1'b0;
        for (int a = 0; a < 2; a++) begin
            w_step[a]    = '0;
            w_sum[a]     = '0;
            w_pos_nxt[a] = r_pos[a];
            if (r_state[a] == ST_ACCEL && w_dir[a] == r_dir[a]) begin
                w_step[a] = w_fast[a] ? SW'(ACC_FAST) : SW'(ACC_SLOW);
            end else begin
                w_step[a] = w_fast[a] ? SW'(STEP_FAST) : SW'(STEP_SLOW);
            end
            w_sum[a] = $signed({1'b0, r_pos[a]}) +
                       ((w_dir[a] == 2'sd1) ? $signed(w_step[a]) : -$signed(w_step[a]));
            if (bus.recenter) begin
                w_pos_nxt[a] = w_init[a];
            end else if (w_upd && w_dir[a] != 2'sd0) begin
                if (w_sum[a] > $signed({1'b0, w_max[a]})) begin
                    w_pos_nxt[a] = w_max[a];
                end else if (w_sum[a] < $signed({1'b0, w_min[a]})) begin
                    w_pos_nxt[a] = w_min[a];
                end else begin
                    w_pos_nxt[a] = w_sum[a][PW-1:0];
                end
            end
            if (w_upd && w_pos_nxt[a] != r_pos[a]) begin
                w_moving_nxt = 1'b1;
            end
        end
    end

    // Datapath registers; tick_d resets high so a tick held through reset is not an edge.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_pos[0] <= PW'(X_INIT);
            r_pos[1] <= PW'(Y_INIT);
            r_tick_d <= 1'b1;
            r_moving <= 1'b0;
        end else begin
            r_pos[0] <= w_pos_nxt[0];
            r_pos[1] <= w_pos_nxt[1];
            r_tick_d <= bus.tick;
            r_moving <= w_moving_nxt;
        end
    end

    assign bus.dot_x   = r_pos[0];
    assign bus.dot_y   = r_pos[1];
    assign bus.moving  = r_moving;
    assign bus.at_edge = {r_pos[1] == PW'(Y_MAX), r_pos[1] == PW'(Y_MIN),
                          r_pos[0] == PW'(X_MAX), r_pos[0] == PW'(X_MIN)};
endmodule

// File: tb/tb_cursor_ctrl.sv
// Directed bench for cursor_ctrl: hand-computed cursor positions across reset, clamp, accel, recenter, enable.
module tb_cursor_ctrl;
    logic clk;
    logic clr_n;
    int   n_vec;
    int   n_err;
    logic mv;

    cursor_ctrl_if #(.JW(10), .PW(10)) bus ();

    cursor_ctrl dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every vector and reports any miscompare.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One tick pulse from a negedge; returns moving as seen after the update edge.
    task automatic tick_once(output logic moved);
        bus.tick = 1'b1;
        @(negedge clk);
        moved = bus.moving;
        bus.tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_recenter();
        bus.recenter = 1'b1;
        @(negedge clk);
        bus.recenter = 1'b0;
        @(negedge clk);
    endtask

    // Hand-computed y trajectory for joy_y=900 held 12 ticks from 171.
    int unsigned exp_t3 [12] = '{191, 211, 231, 251, 271, 291, 311, 331, 371, 411, 451, 471};

    initial begin
        n_vec = 0;
        n_err = 0;
        clr_n        = 1'b0;
        bus.tick     = 1'b0;
        bus.recenter = 1'b0;
        bus.enable   = 1'b1;
        bus.joy_x    = 10'd512;
        bus.joy_y    = 10'd512;
        repeat (3) @(negedge clk);
        check("rst_dot_x", 32'(bus.dot_x), 724);
        check("rst_dot_y", 32'(bus.dot_y), 171);
        check("rst_edge", 32'(bus.at_edge), 0);
        check("rst_moving", 32'(bus.moving), 0);
        clr_n = 1'b1;
        repeat (2) @(negedge clk);

        // T1: dead zone, no motion
        for (int i = 0; i < 5; i++) begin
            tick_once(mv);
            check("t1_moving", 32'(mv), 0);
        end
        check("t1_dot_x", 32'(bus.dot_x), 724);
        check("t1_dot_y", 32'(bus.dot_y), 171);
        check("t1_edge", 32'(bus.at_edge), 0);

        // T2: far-low x with inversion moves +x, clamps at X_MAX
        bus.joy_x = 10'd100;
        tick_once(mv);
        check("t2_dot_x", 32'(bus.dot_x), 734);
        check("t2_moving", 32'(mv), 1);
        check("t2_edge", 32'(bus.at_edge), 32'b0010);
        tick_once(mv);
        check("t2_hold_x", 32'(bus.dot_x), 734);
        check("t2_hold_mv", 32'(mv), 0);
        bus.joy_x = 10'd512;

        // T3: far-high y accelerates after 8 updates and clamps at Y_MAX
        bus.joy_y = 10'd900;
        for (int i = 0; i < 12; i++) begin
            tick_once(mv);
            check($sformatf("t3_y%0d", i), 32'(bus.dot_y), exp_t3[i]);
        end
        check("t3_last_mv", 32'(mv), 1);
        check("t3_edge", 32'(bus.at_edge), 32'b1010);
        tick_once(mv);
        check("t3_clamp_y", 32'(bus.dot_y), 471);
        check("t3_clamp_mv", 32'(mv), 0);

        // T4: slow down-moves then reversal restarts at slow step
        bus.joy_y = 10'd512;
        do_recenter();
        check("rc_dot_x", 32'(bus.dot_x), 724);
        check("rc_dot_y", 32'(bus.dot_y), 171);
        bus.joy_y = 10'd300;
        tick_once(mv);
        check("t4_y0", 32'(bus.dot_y), 161);
        tick_once(mv);
        check("t4_y1", 32'(bus.dot_y), 151);
        tick_once(mv);
        check("t4_y2", 32'(bus.dot_y), 141);
        bus.joy_y = 10'd700;
        tick_once(mv);
        check("t4_rev", 32'(bus.dot_y), 151);

        // enable=0 freezes position and drops the tick edge
        bus.enable = 1'b0;
        tick_once(mv);
        check("dis_y", 32'(bus.dot_y), 151);
        check("dis_mv", 32'(mv), 0);
        bus.enable = 1'b1;
        bus.joy_y = 10'd100;
        tick_once(mv);
        check("en_y", 32'(bus.dot_y), 131);

        // T5: recenter wins over a coincident tick edge; long tick high gives no extra update
        bus.joy_x = 10'd100;
        bus.joy_y = 10'd900;
        tick_once(mv);
        check("t5_pre_x", 32'(bus.dot_x), 734);
        check("t5_pre_y", 32'(bus.dot_y), 151);
        bus.tick     = 1'b1;
        bus.recenter = 1'b1;
        @(negedge clk);
        check("t5_rc_x", 32'(bus.dot_x), 724);
        check("t5_rc_y", 32'(bus.dot_y), 171);
        check("t5_rc_mv", 32'(bus.moving), 0);
        bus.recenter = 1'b0;
        repeat (20) @(negedge clk);
        check("t5_hold_x", 32'(bus.dot_x), 724);
        check("t5_hold_y", 32'(bus.dot_y), 171);
        bus.tick = 1'b0;
        @(negedge clk);

        // T6: async reset mid-ACCEL with tick held high
        bus.joy_x = 10'd512;
        for (int i = 0; i < 9; i++) tick_once(mv);
        check("t6_y9", 32'(bus.dot_y), 371);
        bus.tick = 1'b1;
        @(negedge clk);
        check("t6_accel", 32'(bus.dot_y), 411);
        #2 clr_n = 1'b0;
        #1;
        check("t6_rst_x", 32'(bus.dot_x), 724);
        check("t6_rst_y", 32'(bus.dot_y), 171);
        check("t6_rst_mv", 32'(bus.moving), 0);
        @(negedge clk);
        clr_n = 1'b1;
        repeat (5) @(negedge clk);
        check("t6_noupd_y", 32'(bus.dot_y), 171);
        check("t6_noupd_mv", 32'(bus.moving), 0);
        bus.tick = 1'b0;
        @(negedge clk);
        tick_once(mv);
        check("t6_fresh_y", 32'(bus.dot_y), 191);
        check("t6_fresh_mv", 32'(mv), 1);

        // T7: far-high x with inversion moves -x, lands exactly on X_MIN
        bus.joy_y = 10'd512;
        bus.joy_x = 10'd900;
        for (int i = 0; i < 7; i++) tick_once(mv);
        check("t7_x7", 32'(bus.dot_x), 584);
        tick_once(mv);
        check("t7_x8", 32'(bus.dot_x), 574);
        check("t7_edge", 32'(bus.at_edge), 32'b0001);
        tick_once(mv);
        check("t7_clamp_x", 32'(bus.dot_x), 574);
        check("t7_clamp_mv", 32'(mv), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
